// File: rtl/any1_issue_stage.sv
// ANY-1 issue stage.
//
// Takes the scheduler's per-cycle ROB selection and the operands and instruction read for it.
// Entries are held in a two-entry in-order skid buffer feeding one functional unit over a
// valid/ready handshake.
//
// The stage refuses to accept a ROB id while that entry's "out" flag may still be in flight.
// An id is refused if it was accepted one or two cycles ago, or if it is still buffered.
// It also produces the pexec/pexec2 history that the scheduler consumes.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   selection             bit RIDW set = no selection, else [RIDW-1:0] is the ROB id
//   sel_*                 instruction/operands/flags of the selected entry
//   flush_i               pipeline flush; empties the buffer and clears history
//   sel_ack               selection accepted this cycle (combinational)
//   out_set_v/out_set_id  strobe that sets rob[id].out, one cycle after accept
//   rob_pexec/rob_pexec2  ids accepted one/two cycles ago, all ones if none
//   fu_v/fu_rdy           head-entry handshake to the functional unit
//   fu_*                  head entry contents
//   occupancy             number of buffered entries (0..2)
module any1_issue_stage #(
    parameter int unsigned WID  = 64,
    parameter int unsigned IRW  = 40,
    parameter int unsigned RIDW = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [RIDW:0]   selection,
    input  logic [IRW-1:0]  sel_ir,
    input  logic [WID-1:0]  sel_a,
    input  logic [WID-1:0]  sel_b,
    input  logic [WID-1:0]  sel_c,
    input  logic [WID-1:0]  sel_d,
    input  logic            sel_branch,
    input  logic            sel_memop,
    input  logic            flush_i,
    output logic            sel_ack,
    output logic            out_set_v,
    output logic [RIDW-1:0] out_set_id,
    output logic [RIDW-1:0] rob_pexec,
    output logic [RIDW-1:0] rob_pexec2,
    output logic            fu_v,
    input  logic            fu_rdy,
    output logic [RIDW-1:0] fu_rid,
    output logic [IRW-1:0]  fu_ir,
    output logic [WID-1:0]  fu_a,
    output logic [WID-1:0]  fu_b,
    output logic [WID-1:0]  fu_c,
    output logic [WID-1:0]  fu_d,
    output logic            fu_branch,
    output logic            fu_memop,
    output logic [1:0]      occupancy
);

    localparam logic [RIDW-1:0] RidNone = '1;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } count_e;

    count_e          count_q;
    logic            head_q;
    logic            tail_q;
    logic [RIDW-1:0] rid_q    [2];
    logic [IRW-1:0]  ir_q     [2];
    logic [WID-1:0]  a_q      [2];
    logic [WID-1:0]  b_q      [2];
    logic [WID-1:0]  c_q      [2];
    logic [WID-1:0]  d_q      [2];
    logic            branch_q [2];
    logic            memop_q  [2];

    logic [RIDW-1:0] sel_id;
    logic [1:0]      ent_v;
    logic            dup;
    logic            deq;

    assign sel_id = selection[RIDW-1:0];
    assign deq    = fu_v && fu_rdy;

    // Which physical slots currently hold a live entry.
    always_comb begin
        ent_v = 2'b00;
        case (count_q)
            StOne:   ent_v[head_q] = 1'b1;
            StFull:  ent_v = 2'b11;
            default: ent_v = 2'b00;
        endcase
    end

    // An id may still be visible as "not out" to the scheduler for two cycles after accept,
    // and for as long as it sits in the buffer.
    assign dup = (sel_id == rob_pexec) || (sel_id == rob_pexec2) ||
                 (ent_v[0] && (rid_q[0] == sel_id)) ||
                 (ent_v[1] && (rid_q[1] == sel_id));

    // FULL is judged before any same-cycle dequeue.
    assign sel_ack = !selection[RIDW] && (count_q != StFull) && !dup && !flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q    <= StEmpty;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            out_set_v  <= 1'b0;
            out_set_id <= RidNone;
            rob_pexec  <= RidNone;
            rob_pexec2 <= RidNone;
            for (int i = 0; i < 2; i++) begin
                rid_q[i]    <= '0;
                ir_q[i]     <= '0;
                a_q[i]      <= '0;
                b_q[i]      <= '0;
                c_q[i]      <= '0;
                d_q[i]      <= '0;
                branch_q[i] <= 1'b0;
                memop_q[i]  <= 1'b0;
            end
        end else if (flush_i) begin
            // A concurrent fu_v && fu_rdy is taken by the FU; nothing to undo here.
            count_q    <= StEmpty;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            out_set_v  <= 1'b0;
            out_set_id <= RidNone;
            rob_pexec  <= RidNone;
            rob_pexec2 <= RidNone;
        end else begin
            if (sel_ack) begin
                rid_q[tail_q]    <= sel_id;
                ir_q[tail_q]     <= sel_ir;
                a_q[tail_q]      <= sel_a;
                b_q[tail_q]      <= sel_b;
                c_q[tail_q]      <= sel_c;
                d_q[tail_q]      <= sel_d;
                branch_q[tail_q] <= sel_branch;
                memop_q[tail_q]  <= sel_memop;
                tail_q           <= ~tail_q;
            end
            if (deq) begin
                head_q <= ~head_q;
            end
            if (sel_ack && !deq) begin
                if (count_q == StEmpty) count_q <= StOne;
                else                    count_q <= StFull;
            end else if (deq && !sel_ack) begin
                if (count_q == StFull) count_q <= StOne;
                else                   count_q <= StEmpty;
            end
            out_set_v  <= sel_ack;
            out_set_id <= sel_ack ? sel_id : RidNone;
            rob_pexec2 <= rob_pexec;
            rob_pexec  <= sel_ack ? sel_id : RidNone;
        end
    end

    assign fu_v      = (count_q != StEmpty);
    assign occupancy = count_q;
    assign fu_rid    = rid_q[head_q];
    assign fu_ir     = ir_q[head_q];
    assign fu_a      = a_q[head_q];
    assign fu_b      = b_q[head_q];
    assign fu_c      = c_q[head_q];
    assign fu_d      = d_q[head_q];
    assign fu_branch = branch_q[head_q];
    assign fu_memop  = memop_q[head_q];

endmodule

// File: tb/tb_any1_issue_stage.sv
// Bench for any1_issue_stage: a queue-based reference model checked every cycle on the
// falling edge, plus directed scenarios with literal expectations.
module tb_any1_issue_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [6:0]  selection;
    logic [39:0] sel_ir;
    logic [63:0] sel_a, sel_b, sel_c, sel_d;
    logic        sel_branch, sel_memop, flush_i;
    logic        sel_ack, out_set_v;
    logic [5:0]  out_set_id, rob_pexec, rob_pexec2;
    logic        fu_v, fu_rdy;
    logic [5:0]  fu_rid;
    logic [39:0] fu_ir;
    logic [63:0] fu_a, fu_b, fu_c, fu_d;
    logic        fu_branch, fu_memop;
    logic [1:0]  occupancy;

    any1_issue_stage dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .selection  (selection),
        .sel_ir     (sel_ir),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .sel_c      (sel_c),
        .sel_d      (sel_d),
        .sel_branch (sel_branch),
        .sel_memop  (sel_memop),
        .flush_i    (flush_i),
        .sel_ack    (sel_ack),
        .out_set_v  (out_set_v),
        .out_set_id (out_set_id),
        .rob_pexec  (rob_pexec),
        .rob_pexec2 (rob_pexec2),
        .fu_v       (fu_v),
        .fu_rdy     (fu_rdy),
        .fu_rid     (fu_rid),
        .fu_ir      (fu_ir),
        .fu_a       (fu_a),
        .fu_b       (fu_b),
        .fu_c       (fu_c),
        .fu_d       (fu_d),
        .fu_branch  (fu_branch),
        .fu_memop   (fu_memop),
        .occupancy  (occupancy)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: buffer contents as a queue, history as plain values.
    typedef struct {
        logic [5:0]  rid;
        logic [39:0] ir;
        logic [63:0] a, b, c, d;
        logic        br, mem;
    } ent_t;

    ent_t       mq[$];
    logic [5:0] m_pexec  = 6'h3F;
    logic [5:0] m_pexec2 = 6'h3F;
    logic       m_osv    = 1'b0;
    logic [5:0] m_osid   = 6'h3F;

    function automatic logic model_ack();
        logic [5:0] id;
        id = selection[5:0];
        if (selection[6] || flush_i || mq.size() >= 2) return 1'b0;
        if (id == m_pexec || id == m_pexec2) return 1'b0;
        foreach (mq[i]) if (mq[i].rid == id) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk_i) begin : model_upd
        logic acc;
        ent_t e;
        acc = model_ack();
        if (rst_i || flush_i) begin
            mq.delete();
            m_pexec  = 6'h3F;
            m_pexec2 = 6'h3F;
            m_osv    = 1'b0;
            m_osid   = 6'h3F;
        end else begin
            if (mq.size() > 0 && fu_rdy) void'(mq.pop_front());
            if (acc) begin
                e.rid = selection[5:0];
                e.ir  = sel_ir;
                e.a   = sel_a;
                e.b   = sel_b;
                e.c   = sel_c;
                e.d   = sel_d;
                e.br  = sel_branch;
                e.mem = sel_memop;
                mq.push_back(e);
            end
            m_osv    = acc;
            m_osid   = acc ? selection[5:0] : 6'h3F;
            m_pexec2 = m_pexec;
            m_pexec  = acc ? selection[5:0] : 6'h3F;
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("sel_ack", sel_ack, model_ack());
            check("fu_v", fu_v, mq.size() > 0);
            check("occupancy", occupancy, 64'(mq.size()));
            check("out_set_v", out_set_v, m_osv);
            check("out_set_id", out_set_id, m_osid);
            check("rob_pexec", rob_pexec, m_pexec);
            check("rob_pexec2", rob_pexec2, m_pexec2);
            if (mq.size() > 0) begin
                check("fu_rid", fu_rid, mq[0].rid);
                check("fu_ir", fu_ir, mq[0].ir);
                check("fu_a", fu_a, mq[0].a);
                check("fu_b", fu_b, mq[0].b);
                check("fu_c", fu_c, mq[0].c);
                check("fu_d", fu_d, mq[0].d);
                check("fu_branch", fu_branch, mq[0].br);
                check("fu_memop", fu_memop, mq[0].mem);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_sel(input logic [6:0] s, input logic [63:0] a);
        selection  = s;
        sel_ir     = 40'hC0_0000_0000 | 40'(s);
        sel_a      = a;
        sel_b      = a + 64'd1;
        sel_c      = a + 64'd2;
        sel_d      = a + 64'd3;
        sel_branch = s[0];
        sel_memop  = s[1];
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_fu_v"}, fu_v, 1'b0);
        check({tag, "_occ"}, occupancy, 2'd0);
        check({tag, "_osv"}, out_set_v, 1'b0);
        check({tag, "_osid"}, out_set_id, 6'h3F);
        check({tag, "_pexec"}, rob_pexec, 6'h3F);
        check({tag, "_pexec2"}, rob_pexec2, 6'h3F);
        check({tag, "_fu_rid"}, fu_rid, 6'h00);
        check({tag, "_fu_a"}, fu_a, 64'h0);
        check({tag, "_fu_ir"}, fu_ir, 40'h0);
    endtask

    initial begin
        rst_i   = 1'b1;
        fu_rdy  = 1'b0;
        flush_i = 1'b0;
        drive_sel(7'h7F, 64'h0);
        step();
        step();
        chk_en = 1'b1;
        check_reset_state("rst");
        rst_i = 1'b0;

        // Basic accept, latency and history shift.
        drive_sel(7'h05, 64'h11);
        fu_rdy = 1'b1;
        #1 check("t1_ack", sel_ack, 1'b1);
        step();
        drive_sel(7'h7F, 64'h0);
        check("t1_fu_v", fu_v, 1'b1);
        check("t1_fu_rid", fu_rid, 6'd5);
        check("t1_fu_a", fu_a, 64'h11);
        check("t1_osv", out_set_v, 1'b1);
        check("t1_osid", out_set_id, 6'd5);
        check("t1_pexec", rob_pexec, 6'd5);
        step();
        check("t1_pexec2", rob_pexec2, 6'd5);
        check("t1_pexec_none", rob_pexec, 6'h3F);

        // Fill to FULL with the FU stalled, then drain in order.
        fu_rdy = 1'b0;
        drive_sel(7'h03, 64'h300);
        #1 check("t2_ack3", sel_ack, 1'b1);
        step();
        drive_sel(7'h04, 64'h400);
        #1 check("t2_ack4", sel_ack, 1'b1);
        step();
        drive_sel(7'h09, 64'h900);
        #1 check("t2_ack9", sel_ack, 1'b0);
        check("t2_occ2", occupancy, 2'd2);
        step();
        drive_sel(7'h7F, 64'h0);
        fu_rdy = 1'b1;
        check("t2_rid3", fu_rid, 6'd3);
        step();
        check("t2_rid4", fu_rid, 6'd4);
        check("t2_occ1", occupancy, 2'd1);
        step();
        check("t2_occ0", occupancy, 2'd0);

        // Back-to-back reselection of the same id is suppressed.
        drive_sel(7'h0A, 64'hA0);
        #1 check("t3_ack_first", sel_ack, 1'b1);
        step();
        drive_sel(7'h0A, 64'hA0);
        #1 check("t3_ack_second", sel_ack, 1'b0);
        check("t3_osv_pulse", out_set_v, 1'b1);
        step();
        drive_sel(7'h7F, 64'h0);
        check("t3_osv_once", out_set_v, 1'b0);
        step();

        // Accept and dequeue together in ONE keeps one entry, the new one at head.
        fu_rdy = 1'b0;
        drive_sel(7'h02, 64'h200);
        step();
        drive_sel(7'h07, 64'h700);
        fu_rdy = 1'b1;
        #1 check("t4_ack7", sel_ack, 1'b1);
        check("t4_rid2", fu_rid, 6'd2);
        step();
        drive_sel(7'h7F, 64'h0);
        check("t4_occ", occupancy, 2'd1);
        check("t4_rid7", fu_rid, 6'd7);
        step();

        // FULL refuses even when a dequeue happens in the same cycle.
        fu_rdy = 1'b0;
        drive_sel(7'h20, 64'h2000);
        step();
        drive_sel(7'h21, 64'h2100);
        step();
        drive_sel(7'h22, 64'h2200);
        fu_rdy = 1'b1;
        #1 check("t5_full_ack", sel_ack, 1'b0);
        check("t5_occ2", occupancy, 2'd2);
        step();
        drive_sel(7'h7F, 64'h0);
        check("t5_occ1", occupancy, 2'd1);
        check("t5_rid21", fu_rid, 6'h21);
        step();
        check("t5_occ0", occupancy, 2'd0);

        // Flush beats accept and dequeue.
        fu_rdy = 1'b0;
        drive_sel(7'h14, 64'h1400);
        step();
        drive_sel(7'h15, 64'h1500);
        step();
        drive_sel(7'h0C, 64'hC00);
        flush_i = 1'b1;
        fu_rdy  = 1'b1;
        #1 check("t6_flush_ack", sel_ack, 1'b0);
        check("t6_occ2", occupancy, 2'd2);
        step();
        flush_i = 1'b0;
        drive_sel(7'h15, 64'h1550);
        check("t6_fu_v", fu_v, 1'b0);
        check("t6_occ", occupancy, 2'd0);
        check("t6_pexec", rob_pexec, 6'h3F);
        check("t6_pexec2", rob_pexec2, 6'h3F);
        check("t6_osv", out_set_v, 1'b0);
        #1 check("t6_reaccept", sel_ack, 1'b1);
        step();
        drive_sel(7'h7F, 64'h0);
        check("t6_rid15", fu_rid, 6'h15);
        check("t6_a15", fu_a, 64'h1550);
        step();

        // Idle selections, then reset while one entry is held.
        for (int i = 0; i < 3; i++) begin
            #1 check("t7_idle_ack", sel_ack, 1'b0);
            check("t7_idle_pexec", rob_pexec, 6'h3F);
            step();
        end
        fu_rdy = 1'b0;
        drive_sel(7'h30, 64'hDEAD);
        step();
        check("t7_occ1", occupancy, 2'd1);
        rst_i  = 1'b1;
        fu_rdy = 1'b1;
        drive_sel(7'h31, 64'hBEEF);
        step();
        rst_i = 1'b0;
        drive_sel(7'h7F, 64'h0);
        check_reset_state("t7");
        step();
        step();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
